// File: rtl/aquila_dev_pkg.sv
// rtl/aquila_dev_pkg.sv - shared types and constants for the Aquila device router
package aquila_dev_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } dev_rt_state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISS,
        ERR_TMO,
        ERR_BUSY
    } dev_err_t;

    // addr[31:30] value that marks the memory-mapped device region
    localparam logic [1:0] DEV_REGION = 2'b11;

endpackage

// File: rtl/aquila_dev_decode.sv
// rtl/aquila_dev_decode.sv - region/ID priority decoder selecting the target slave
module aquila_dev_decode #(
    parameter int                   NUM_SLV = 3,
    parameter logic [NUM_SLV*4-1:0] SLV_ID  = '0,
    parameter int                   SEL_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic [1:0]       region,
    input  logic [3:0]       id,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);
    import aquila_dev_pkg::*;

    // scan from the top so the lowest matching slave index is the one left standing
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if (region == DEV_REGION && id == SLV_ID[k*4 +: 4]) begin
                hit = 1'b1;
                sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/aquila_dev_router.sv
// rtl/aquila_dev_router.sv - single-outstanding router from the core device port to N slaves
module aquila_dev_router #(
    parameter int                   NUM_SLV  = 3,
    parameter int                   DATA_W   = 32,
    parameter int                   ADDR_W   = 32,
    parameter logic [NUM_SLV*4-1:0] SLV_ID   = {4'h2, 4'h4, 4'h0},
    parameter int                   TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0]    ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_strobe_i,
    input  logic [ADDR_W-1:0]         m_addr_i,
    input  logic                      m_rw_i,
    input  logic [DATA_W/8-1:0]       m_be_i,
    input  logic [DATA_W-1:0]         m_data_i,
    output logic                      m_ready_o,
    output logic [DATA_W-1:0]         m_data_o,
    output logic [NUM_SLV-1:0]        s_strobe_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic                      s_rw_o,
    output logic [DATA_W/8-1:0]       s_be_o,
    output logic [DATA_W-1:0]         s_data_o,
    input  logic [NUM_SLV-1:0]        s_ready_i,
    input  logic [NUM_SLV*DATA_W-1:0] s_data_i,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic [ADDR_W-1:0]         err_addr_o
);
    import aquila_dev_pkg::*;

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    // keep at least one bit so a disabled timeout still elaborates
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    dev_rt_state_t     state;
    dev_rt_state_t     state_nxt;
    dev_err_t          err_code;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  dec_sel;
    logic              dec_hit;
    logic              sel_ready;
    logic              accept;
    logic              capture;
    logic              expire;
    logic              busy_strobe;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata;

    aquila_dev_decode #(
        .NUM_SLV (NUM_SLV),
        .SLV_ID  (SLV_ID),
        .SEL_W   (SEL_W)
    ) u_decode (
        .region (m_addr_i[31:30]),
        .id     (m_addr_i[27:24]),
        .hit    (dec_hit),
        .sel    (dec_sel)
    );

    // only the selected slave's ready is ever looked at
    assign sel_ready  = s_ready_i[sel];
    assign m_ready_o  = (state == RESP);
    assign busy_o     = (state != IDLE);
    assign m_data_o   = rdata;
    assign err_code_o = err_code;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and per-cycle transaction events
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        capture     = 1'b0;
        expire      = 1'b0;
        busy_strobe = 1'b0;
        case (state)
            IDLE: begin
                if (m_strobe_i) begin
                    accept    = 1'b1;
                    state_nxt = dec_hit ? REQ : RESP;
                end
            end
            REQ: begin
                busy_strobe = m_strobe_i;
                state_nxt   = WAIT;
            end
            WAIT: begin
                busy_strobe = m_strobe_i;
                if (sel_ready) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                busy_strobe = m_strobe_i;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // one-hot request pulse to the selected slave during REQ
    always_comb begin
        s_strobe_o = '0;
        if (state == REQ) begin
            s_strobe_o[sel] = 1'b1;
        end
    end

    // request latches, response data and sticky error record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_addr_o   <= '0;
            s_rw_o     <= 1'b0;
            s_be_o     <= '0;
            s_data_o   <= '0;
            sel        <= '0;
            rdata      <= '0;
            err_o      <= 1'b0;
            err_code   <= ERR_NONE;
            err_addr_o <= '0;
        end else begin
            if (accept) begin
                s_addr_o <= m_addr_i;
                s_rw_o   <= m_rw_i;
                s_be_o   <= m_be_i;
                s_data_o <= m_data_i;
                sel      <= dec_sel;
                if (!dec_hit) begin
                    rdata      <= ERR_DATA;
                    err_code   <= ERR_MISS;
                    err_addr_o <= m_addr_i;
                end
            end
            if (busy_strobe) begin
                err_code   <= ERR_BUSY;
                err_addr_o <= m_addr_i;
            end
            if (capture) begin
                rdata <= s_data_i[sel*DATA_W +: DATA_W];
            end
            if (expire) begin
                rdata      <= ERR_DATA;
                err_code   <= ERR_TMO;
                err_addr_o <= s_addr_o;
            end
            // registered so the pulse lands in the RESP cycle of the failing access
            err_o <= expire || (accept && !dec_hit);
        end
    end

    // wait-cycle counter: cleared in REQ, saturating in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == REQ) begin
            cnt <= '0;
        end else if (state == WAIT && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_aquila_dev_router.sv
// tb/tb_aquila_dev_router.sv - randomized self-checking bench for aquila_dev_router
module tb_aquila_dev_router;

    localparam int          NSLV     = 5;
    localparam int          TMO      = 16;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 m_strobe_i = 1'b0;
    logic [31:0]          m_addr_i = '0;
    logic                 m_rw_i = 1'b0;
    logic [3:0]           m_be_i = '0;
    logic [31:0]          m_data_i = '0;
    logic                 m_ready_o;
    logic [31:0]          m_data_o;
    logic [NSLV-1:0]      s_strobe_o;
    logic [31:0]          s_addr_o;
    logic                 s_rw_o;
    logic [3:0]           s_be_o;
    logic [31:0]          s_data_o;
    logic [NSLV-1:0]      s_ready_i = '0;
    logic [NSLV*32-1:0]   s_data_i = '0;
    logic                 busy_o;
    logic                 err_o;
    logic [1:0]           err_code_o;
    logic [31:0]          err_addr_o;

    int checks = 0;
    int failures = 0;

    // model of the sticky error record
    int          exp_code = 0;
    logic [31:0] exp_addr = '0;

    // slave k answers to device ID slv_ids[k]; slaves 3 and 4 share ID 3
    int slv_ids[NSLV] = '{0, 4, 2, 3, 3};

    aquila_dev_router #(
        .NUM_SLV  (NSLV),
        .DATA_W   (32),
        .ADDR_W   (32),
        .SLV_ID   ({4'h3, 4'h3, 4'h2, 4'h4, 4'h0}),
        .TIMEOUT  (TMO),
        .ERR_DATA (ERR_WORD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_strobe_i (m_strobe_i),
        .m_addr_i   (m_addr_i),
        .m_rw_i     (m_rw_i),
        .m_be_i     (m_be_i),
        .m_data_i   (m_data_i),
        .m_ready_o  (m_ready_o),
        .m_data_o   (m_data_o),
        .s_strobe_o (s_strobe_o),
        .s_addr_o   (s_addr_o),
        .s_rw_o     (s_rw_o),
        .s_be_o     (s_be_o),
        .s_data_o   (s_data_o),
        .s_ready_i  (s_ready_i),
        .s_data_i   (s_data_i),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .err_addr_o (err_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // target slave for an address, -1 when nothing is mapped there
    function automatic int route(input logic [31:0] a);
        if (a[31:30] != 2'b11) return -1;
        for (int k = 0; k < NSLV; k++) begin
            if (int'(a[27:24]) == slv_ids[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_strobe"}, 64'(s_strobe_o), 0);
        check_eq({tag, "_ready"},  64'(m_ready_o), 0);
        check_eq({tag, "_mdata"},  64'(m_data_o), 0);
        check_eq({tag, "_busy"},   64'(busy_o), 0);
        check_eq({tag, "_err"},    64'(err_o), 0);
        check_eq({tag, "_code"},   64'(err_code_o), 0);
        check_eq({tag, "_eaddr"},  64'(err_addr_o), 0);
        check_eq({tag, "_saddr"},  64'({s_addr_o, s_data_o}), 0);
        check_eq({tag, "_sctl"},   64'({s_rw_o, s_be_o}), 0);
    endtask

    // one core access; cycle 0 carries the strobe, the target slave pulses ready
    // in cycle 1+delay, an optional second strobe arrives in cycle busy_cyc
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic rw,
                           input int delay, input logic [31:0] rd_val,
                           input int busy_cyc_in, input logic [31:0] busy_addr,
                           input bit noise_all);
        int          tgt, ready_cyc, exp_rdy_cyc, last_cyc, busy_cyc;
        logic [31:0] exp_data, wdata;
        logic [3:0]  be;
        bit          exp_err, latch_ok;
        int          strb_n, strb_cyc, rdy_n, rdy_cyc, err_n, err_cyc, busy_n;
        logic [NSLV-1:0] strb_val, noise;
        logic [31:0] data_at;

        tgt = route(addr);
        be = 4'($urandom);
        wdata = $urandom;
        ready_cyc = 1 + delay;
        if (tgt < 0) begin
            exp_rdy_cyc = 1; exp_data = ERR_WORD; exp_err = 1'b1;
            exp_code = 1; exp_addr = addr;
        end else if (ready_cyc <= TMO + 1) begin
            exp_rdy_cyc = ready_cyc + 1; exp_data = rd_val; exp_err = 1'b0;
        end else begin
            exp_rdy_cyc = TMO + 2; exp_data = ERR_WORD; exp_err = 1'b1;
            exp_code = 2; exp_addr = addr;
        end
        busy_cyc = busy_cyc_in;
        if (!(tgt >= 0 && !exp_err && busy_cyc >= 2 && busy_cyc <= exp_rdy_cyc)) busy_cyc = 0;
        if (busy_cyc != 0) begin
            exp_code = 3; exp_addr = busy_addr;
        end
        last_cyc = exp_rdy_cyc + 2;
        if (tgt >= 0 && ready_cyc > last_cyc) last_cyc = ready_cyc;

        strb_n = 0; strb_cyc = -1; strb_val = '0; rdy_n = 0; rdy_cyc = -1;
        err_n = 0; err_cyc = -1; busy_n = 0; data_at = '0; latch_ok = 1'b0;
        for (int c = 0; c <= last_cyc; c++) begin
            @(posedge clk);
            #1;
            m_strobe_i = (c == 0) || (busy_cyc != 0 && c == busy_cyc);
            m_addr_i   = (c == 0) ? addr : ((c == busy_cyc) ? busy_addr : $urandom);
            m_rw_i     = (c == 0) ? rw : 1'($urandom);
            m_be_i     = (c == 0) ? be : 4'($urandom);
            m_data_i   = (c == 0) ? wdata : $urandom;
            for (int k = 0; k < NSLV; k++) s_data_i[k*32 +: 32] = $urandom;
            noise = noise_all ? '1 : NSLV'($urandom);
            if (tgt >= 0) begin
                noise[tgt] = (c == ready_cyc);
                if (c == ready_cyc) s_data_i[tgt*32 +: 32] = rd_val;
            end
            s_ready_i = noise;
            @(negedge clk);
            if (s_strobe_o != '0) begin
                strb_n++; strb_cyc = c; strb_val = s_strobe_o;
                latch_ok = (s_addr_o == addr) && (s_rw_o == rw) && (s_be_o == be) && (s_data_o == wdata);
            end
            if (m_ready_o) begin rdy_n++; rdy_cyc = c; data_at = m_data_o; end
            if (err_o) begin err_n++; err_cyc = c; end
            if (busy_o) busy_n++;
        end
        m_strobe_i = 1'b0;
        s_ready_i = '0;

        check_eq({tag, "_strobe_n"}, 64'(strb_n), (tgt < 0) ? 0 : 1);
        if (tgt >= 0) begin
            check_eq({tag, "_strobe_cyc"}, 64'(strb_cyc), 1);
            check_eq({tag, "_strobe_val"}, 64'(strb_val), 64'(1) << tgt);
            check_eq({tag, "_latch"}, 64'(latch_ok), 1);
        end
        check_eq({tag, "_ready_n"}, 64'(rdy_n), 1);
        check_eq({tag, "_ready_cyc"}, 64'(rdy_cyc), 64'(exp_rdy_cyc));
        check_eq({tag, "_data"}, 64'(data_at), 64'(exp_data));
        check_eq({tag, "_err_n"}, 64'(err_n), exp_err ? 1 : 0);
        if (exp_err) check_eq({tag, "_err_cyc"}, 64'(err_cyc), 64'(exp_rdy_cyc));
        check_eq({tag, "_busy_n"}, 64'(busy_n), 64'(exp_rdy_cyc));
        check_eq({tag, "_code"}, 64'(err_code_o), 64'(exp_code));
        check_eq({tag, "_eaddr"}, 64'(err_addr_o), 64'(exp_addr));
    endtask

    // reset in the middle of a wait, then a late ready from the old target
    task automatic reset_mid_wait();
        int ghost_n;
        @(posedge clk); #1;
        m_strobe_i = 1'b1; m_addr_i = 32'hC000_0000; m_rw_i = 1'b0;
        m_be_i = 4'hF; m_data_i = 32'h1234_5678;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            m_strobe_i = 1'b0;
            s_ready_i = '0;
        end
        @(negedge clk);
        check_eq("t5_busy_before", 64'(busy_o), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        exp_code = 0; exp_addr = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ghost_n = 0;
        for (int c = 0; c < 4; c++) begin
            s_ready_i = '1;
            s_data_i[31:0] = 32'hBAD0_0000;
            @(negedge clk);
            if (m_ready_o || busy_o || s_strobe_o != '0) ghost_n++;
            @(posedge clk); #1;
        end
        s_ready_i = '0;
        check_eq("t5_late_ready_ignored", 64'(ghost_n), 0);
    endtask

    initial begin
        logic [31:0] a;
        int          d, pick, bc;
        bit          nz;

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_release");

        run_txn("t1_read_hit",  32'hC400_0000, 1'b0, 5,  32'h0000_00A5, 0, '0, 1'b0);
        run_txn("t2_write_miss", 32'hC700_0010, 1'b1, 0, '0, 0, '0, 1'b0);
        run_txn("t3_timeout",   32'hC000_0000, 1'b0, 30, 32'h5555_0000, 0, '0, 1'b0);
        run_txn("t3_ready_at_expiry", 32'hC000_0040, 1'b0, 16, 32'h0BAD_F00D, 0, '0, 1'b0);
        run_txn("t4_busy_strobe", 32'hC200_0000, 1'b0, 6, 32'h7777_1111, 3, 32'hC000_0004, 1'b0);
        run_txn("t4_busy_in_resp", 32'hC400_0008, 1'b1, 1, 32'h2222_3333, 3, 32'hC400_00F0, 1'b0);
        reset_mid_wait();
        run_txn("t5_after_reset", 32'hC400_0100, 1'b0, 1, 32'hCAFE_0001, 0, '0, 1'b0);
        run_txn("t6_dup_id", 32'hC300_0000, 1'b0, 4, 32'h0000_0D0D, 0, '0, 1'b1);
        run_txn("miss_region", 32'h4300_0000, 1'b0, 0, '0, 0, '0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            pick = $urandom_range(0, 9);
            if (pick < 2) a[31:30] = 2'($urandom_range(0, 2));
            else a[31:30] = 2'b11;
            if (pick >= 2 && pick < 8) a[27:24] = 4'(slv_ids[$urandom_range(0, NSLV - 1)]);
            d = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 8);
            bc = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 9) : 0;
            nz = ($urandom_range(0, 4) == 0);
            run_txn("rand", a, 1'($urandom), d, $urandom, bc, $urandom, nz);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
